// File: rtl/recip_pkg.sv
// Shared Q-format constants, FSM state type and seed-table generator for the
// Newton-Raphson mantissa reciprocal engine.
package recip_pkg;

  localparam int unsigned MANT_WIDTH  = 24;              // Q1.23 divisor
  localparam int unsigned RECIP_WIDTH = MANT_WIDTH + 1;  // Q1.24 reciprocal
  localparam int unsigned T_WIDTH     = MANT_WIDTH + 2;  // Q2.24 intermediate

  localparam logic [T_WIDTH-1:0]     TWO_Q2_24   = 26'h2000000;
  localparam logic [RECIP_WIDTH-1:0] ONE_Q1_24   = 25'h1000000;
  localparam logic [RECIP_WIDTH-1:0] INVAL_RECIP = 25'h1FFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_MUL_T,
    ST_MUL_Y,
    ST_DONE
  } state_e;

  // round(2^24 / (1 + (idx+0.5)/2^seed_bits)) == round(2^(25+sb) / (2^(sb+1) + 2*idx + 1))
  function automatic logic [RECIP_WIDTH-1:0] seed_entry(input int unsigned idx,
                                                        input int unsigned seed_bits);
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] quo;
    num = 64'd1 << (25 + seed_bits);
    den = (64'd1 << (seed_bits + 1)) + 64'(2 * idx + 1);
    quo = (num + (den >> 1)) / den;
    return quo[RECIP_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/newton_recip_seq_if.sv
// Valid/ready bundle between the FP unpack stage, the reciprocal engine and
// the exponent/repack stage.
interface newton_recip_seq_if #(
  parameter int unsigned MANT_W = 24
);
  logic              i_valid;
  logic              o_ready;
  logic [MANT_W-1:0] i_mant;
  logic              o_valid;
  logic              i_ready;
  logic [MANT_W:0]   o_recip;
  logic              o_inval;

  modport master (
    output i_valid, i_mant, i_ready,
    input  o_ready, o_valid, o_recip, o_inval
  );

  modport slave (
    input  i_valid, i_mant, i_ready,
    output o_ready, o_valid, o_recip, o_inval
  );
endinterface

// File: rtl/recip_seed_lut.sv
// Combinational seed ROM: initial reciprocal estimate indexed by the leading
// fraction bits of the divisor mantissa.
module recip_seed_lut
  import recip_pkg::*;
#(
  parameter int unsigned SEED_BITS = 6,
  parameter int unsigned OUT_W     = RECIP_WIDTH
) (
  input  logic [SEED_BITS-1:0] idx,
  output logic [OUT_W-1:0]     seed
);

  localparam int unsigned DEPTH = 1 << SEED_BITS;

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = OUT_W'(seed_entry(int'(g), SEED_BITS));
  end

  assign seed = rom[idx];

endmodule

// File: rtl/newton_recip_seq.sv
// Iterative Newton-Raphson Q1.24 mantissa reciprocal with one time-shared,
// registered multiplier. Optional macro NEWTON_ROUND_EN rounds the final step.
module newton_recip_seq
  import recip_pkg::*;
#(
  parameter int unsigned MANT_W    = MANT_WIDTH,
  parameter int unsigned ITER      = 2,
  parameter int unsigned SEED_BITS = 6
) (
  input logic               clk,
  input logic               rst_n,
  newton_recip_seq_if.slave bus
);

  localparam int unsigned RW = MANT_W + 1;
  localparam int unsigned TW = MANT_W + 2;
  localparam int unsigned PW = 2 * TW;

  state_e            state_q, state_d;
  logic [MANT_W-1:0] d_q, d_d;
  logic [RW-1:0]     y_q, y_d;
  logic [TW-1:0]     t_q, t_d;
  logic [1:0]        k_q, k_d;
  logic              inval_q, inval_d;
  logic              one_q, one_d;

  logic [RW-1:0] seed;
  logic [TW-1:0] e_val;
  logic [TW-1:0] mul_b;
  logic [PW-1:0] a_ext, b_ext, prod, prod_y;
  logic          last;
  logic          unused_bits;

  recip_seed_lut #(
    .SEED_BITS(SEED_BITS),
    .OUT_W    (RW)
  ) u_seed_lut (
    .idx (d_q[MANT_W-2 -: SEED_BITS]),
    .seed(seed)
  );

  // Both MUL states share y as one operand; only the other operand is muxed.
  // Operands are extended to full width so the low product bits are the
  // two's complement result for the signed error term.
  assign e_val = TWO_Q2_24 - t_q;
  assign mul_b = (state_q == ST_MUL_T) ? {2'b00, d_q} : e_val;
  assign a_ext = {{(PW-RW){1'b0}}, y_q};
  assign b_ext = {{(PW-TW){mul_b[TW-1]}}, mul_b};
  assign prod  = a_ext * b_ext;
  assign last  = (k_q == 2'(ITER - 1));

`ifdef NEWTON_ROUND_EN
  assign prod_y = last ? (prod + (PW'(1) << (MANT_W - 1))) : prod;
`else
  assign prod_y = prod;
`endif

  assign unused_bits = ^{prod[PW-1:2*MANT_W+1], prod[MANT_W-2:0],
                         prod_y[PW-1:2*MANT_W+1], prod_y[MANT_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      k_q     <= '0;
      inval_q <= 1'b0;
      one_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      y_q     <= y_d;
      t_q     <= t_d;
      k_q     <= k_d;
      inval_q <= inval_d;
      one_q   <= one_d;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    y_d     = y_q;
    t_d     = t_q;
    k_d     = k_q;
    inval_d = inval_q;
    one_d   = one_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_valid) begin
          d_d     = bus.i_mant;
          inval_d = ~bus.i_mant[MANT_W-1];
          one_d   = (bus.i_mant == {1'b1, {(MANT_W-1){1'b0}}});
          state_d = ST_SEED;
        end
      end
      ST_SEED: begin
        y_d     = seed;
        k_d     = '0;
        state_d = ST_MUL_T;
      end
      ST_MUL_T: begin
        t_d     = prod[2*MANT_W:MANT_W-1];
        state_d = ST_MUL_Y;
      end
      ST_MUL_Y: begin
        y_d     = prod_y[2*MANT_W:MANT_W];
        k_d     = k_q + 2'd1;
        state_d = last ? ST_DONE : ST_MUL_T;
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Special cases override the iterated value so latency stays uniform.
  always_comb begin
    bus.o_ready = (state_q == ST_IDLE);
    bus.o_valid = (state_q == ST_DONE);
    bus.o_recip = '0;
    bus.o_inval = 1'b0;
    if (state_q == ST_DONE) begin
      bus.o_inval = inval_q;
      if (inval_q)                       bus.o_recip = INVAL_RECIP;
      else if (one_q || y_q > ONE_Q1_24) bus.o_recip = ONE_Q1_24;
      else                               bus.o_recip = y_q;
    end
  end

endmodule

// File: tb/tb_newton_recip_seq.sv
// Directed and random-sweep bench for newton_recip_seq: latency, result
// accuracy, special cases, backpressure and mid-operation reset.
module tb_newton_recip_seq;

`ifdef NEWTON_ROUND_EN
  localparam int unsigned TOL = 2;
`else
  localparam int unsigned TOL = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  newton_recip_seq_if #(.MANT_W(24)) bus ();

  newton_recip_seq #(
    .MANT_W   (24),
    .ITER     (2),
    .SEED_BITS(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp, input int unsigned tol = 0);
    logic [63:0] diff;
    diff = (obs > exp) ? obs - exp : exp - obs;
    checks++;
    if (diff > 64'(tol)) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Reference 1/d in Q1.24: 2^47/d_int, rounded to nearest.
  function automatic logic [63:0] ref_recip(input logic [23:0] m);
    return (((64'd1 << 48) / {40'd0, m}) + 64'd1) >> 1;
  endfunction

  task automatic send(input logic [23:0] m);
    int unsigned n = 0;
    while (!bus.o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
    bus.i_mant  = m;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [24:0] exp,
                         input int unsigned tol, input logic inv, input bit release_r);
    int unsigned lat = 0;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_recip"}, 64'(bus.o_recip), 64'(exp), tol);
    check({tag, "_inval"}, 64'(bus.o_inval), 64'(inv));
    if (release_r) begin
      bus.i_ready = 1'b1;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      check({tag, "_vld_clr"}, 64'(bus.o_valid), 64'd0);
      check({tag, "_rdy_set"}, 64'(bus.o_ready), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [23:0] m;

    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_mant  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_recip", 64'(bus.o_recip), 64'd0);
    check("rst_inval", 64'(bus.o_inval), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    send(24'h800000); collect("one",  25'h1000000, 0,   1'b0, 1'b1);
    send(24'hC00000); collect("c00",  25'h0AAAAAB, TOL, 1'b0, 1'b1);
    send(24'hFFFFFF); collect("fff",  25'h0800001, TOL, 1'b0, 1'b1);
    send(24'h400000); collect("inv",  25'h1FFFFFF, 0,   1'b1, 1'b1);

    // Backpressure: result held while a second request waits in DONE.
    send(24'hC00000); collect("bp", 25'h0AAAAAB, TOL, 1'b0, 1'b0);
    bus.i_mant  = 24'hA00000;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_recip", 64'(bus.o_recip), 64'h0AAAAAB, TOL);
      check("bp_hold_valid", 64'(bus.o_valid), 64'd1);
      check("bp_hold_ready", 64'(bus.o_ready), 64'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    check("bp_idle_ready", 64'(bus.o_ready), 64'd1);
    check("bp_idle_valid", 64'(bus.o_valid), 64'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("bp_accept", 64'(bus.o_ready), 64'd0);
    collect("bp2", 25'h0CCCCCD, TOL, 1'b0, 1'b1);

    // Reset during the second MUL_Y aborts without producing a result.
    send(24'hE00000);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.o_valid), 64'd0);
    check("abort_ready", 64'(bus.o_ready), 64'd1);
    check("abort_recip", 64'(bus.o_recip), 64'd0);
    #10 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_result", 64'(bus.o_valid), 64'd0);
    check("abort_idle", 64'(bus.o_ready), 64'd1);
    send(24'hA00000); collect("post_rst", 25'h0CCCCCD, TOL, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      r = $urandom();
      m = {1'b1, r[22:0]};
      send(m);
      collect("rand", ref_recip(m)[24:0], TOL, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/newton_recip_seq.md
Name: newton_recip_seq

Overview:
Iterative Newton-Raphson mantissa reciprocal engine for the floating-point reciprocal datapath. It accepts a normalized 24-bit mantissa d in [1,2) and returns 1/d in Q1.24 using one time-shared registered multiplier, the same MULT_REG-style stage the APM provides. It sits between the FP unpack stage and the exponent/repack stage, with valid/ready handshakes on both sides.

Parameters:
MANT_W, 24, input mantissa width (Q1.23 with hidden bit at MSB)
ITER, 2, number of Newton iterations (1..3)
SEED_BITS, 6, fractional bits of d used to index the seed LUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input mantissa valid
o_ready  out  1  engine can accept input (high only in IDLE)
i_mant  in  MANT_W  divisor mantissa, Q1.23; bit 23 must be 1
o_valid  out  1  result valid, held until accepted
i_ready  in  1  downstream accepts result
o_recip  out  MANT_W+1  reciprocal, Q1.24, range (0.5, 1.0]
o_inval  out  1  input was not normalized (i_mant[23]==0)

Behaviour:
- Reset (async, rst_n=0): state IDLE; o_ready=1, o_valid=0, o_recip=0, o_inval=0; internal y/t/d registers cleared. Reset at any point aborts the operation silently; no result is produced.
- States: IDLE, SEED, MUL_T, MUL_Y, DONE.
- IDLE: o_ready=1. On i_valid&&o_ready, capture d=i_mant and go to SEED.
- SEED: y0 = LUT[d[22 -: SEED_BITS]] = round(2^24/(1+(idx+0.5)/2^SEED_BITS)); iteration counter k=0; go to MUL_T.
- MUL_T: t = (d*y)>>23, truncated to Q2.24; go to MUL_Y.
- MUL_Y: e = 2.0 - t (Q2.24, 26-bit two's complement); y = (y*e)>>24, truncated to Q1.24; k++. If k==ITER go to DONE, else go to MUL_T.
- Only one multiplier (25x26 unsigned/signed product, registered output) is instantiated. Each MUL state uses it for exactly one cycle.
- Latency: for acceptance edge E0, o_valid rises after edge E0+1+2*ITER (5 cycles for ITER=2).
- DONE: o_valid=1. o_recip and o_inval stay stable while i_ready=0. On i_valid... ignored. On i_ready go to IDLE; o_ready rises the next cycle. No accept in DONE, so throughput is one result per 2+2*ITER cycles minimum.
- Result clamp: if y > 1.0, o_recip = 25'h1000000. Special case d==24'h800000 bypasses iteration and gives exactly 25'h1000000 at the same latency.
- Invalid input (i_mant[23]==0): o_inval=1, o_recip=25'h1FFFFFF, same latency and handshake.
- Accuracy: |o_recip - 2^24/d| <= 4 LSB for ITER=2, SEED_BITS=6.

Optional Feature:
NEWTON_ROUND_EN: when defined, the final MUL_Y product is rounded to nearest (add 2^23 before >>24, then clamp) and the accuracy bound tightens to <=2 LSB. When undefined, truncation is used everywhere. Latency is identical in both cases.

Decomposition:
- Package recip_pkg holds MANT_W/Q-format constants, the state enum type, the constant TWO_Q2_24, and a function computing seed LUT entries.
- One sub-module, recip_seed_lut: combinational ROM with 2^SEED_BITS entries, 25-bit wide, indexed by the d fraction MSBs.

Test Plan:
- i_mant=24'h800000 -> o_valid 5 cycles after accept, o_recip=25'h1000000 exactly, o_inval=0.
- i_mant=24'hC00000 (1.5) -> o_recip within 4 LSB of 25'h0AAAAAB.
- i_mant=24'hFFFFFF -> o_recip within 4 LSB of 25'h0800001; no clamp artefact.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid and drive a second i_valid -> o_recip stable, o_ready=0, second input not accepted until a cycle after the i_ready handshake.
- Pull rst_n low during the second MUL_Y -> o_valid=0 and o_ready=1 immediately. A following i_mant=24'hA00000 (1.25) gives 25'h0CCCCCD within 4 LSB.
- i_mant=24'h400000 -> o_inval=1, o_recip=25'h1FFFFFF after 5 cycles. Sweep 1000 random normalized mantissas against the reference 2^48/d bound.
